// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian word-count-prefixed byte
// stream into 32-bit words, writes them to IMEM and holds the core until done.
`timescale 1ns/1ps
module imem_loader #(
    parameter int unsigned MAX_WORDS      = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);

    localparam int WI_W = $clog2(MAX_WORDS + 1);
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [WI_W-1:0] word_idx_q, word_idx_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [31:0]     len_q, len_d;
    logic [31:0]     word_q, word_d;
    logic            imem_we_q, imem_we_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;
    logic            core_rst_n_q, core_rst_n_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic        accept;
    logic        last_byte;
    logic        timed_out;
    logic        last_word;
    logic [4:0]  lane_lsb;
    logic [31:0] word_off;

    assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign accept     = byte_valid && byte_ready;
    assign last_byte  = (byte_cnt_q == 2'd3);
    assign lane_lsb   = {byte_cnt_q, 3'b000};
    assign timed_out  = TO_EN && !accept && (to_cnt_q == TO_LAST);
    assign last_word  = (32'(word_idx_q) == (len_q - 32'd1));
    assign word_off   = 32'(word_idx_q) << 2;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            to_cnt_q     <= '0;
            len_q        <= '0;
            word_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            to_cnt_q     <= to_cnt_d;
            len_q        <= len_d;
            word_q       <= word_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        to_cnt_d   = to_cnt_q;
        len_d      = len_q;
        word_d     = word_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    to_cnt_d   = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d[lane_lsb +: 8] = byte_data;
                    byte_cnt_d           = byte_cnt_q + 2'd1;
                    to_cnt_d             = '0;
                    if (last_byte) begin
                        // len_d is the full 32-bit count, so huge N is rejected too
                        if ((len_d == 32'd0) || (len_d > MAX_N)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[lane_lsb +: 8] = byte_data;
                    byte_cnt_d            = byte_cnt_q + 2'd1;
                    to_cnt_d              = '0;
                    if (last_byte) begin
                        state_d = S_WRITE;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else if (TO_EN) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    state_d    = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state
    always_comb begin
        imem_we_d    = (state_q == S_DATA) && accept && last_byte;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (imem_we_d) begin
            imem_addr_d  = BASE_ADDR + word_off;
            imem_wdata_d = word_d;
        end
        core_rst_n_d = (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: length-check vector table, scoreboarded IMEM writes,
// and hand-written sequences for reload, timeout and mid-load reset.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned MAXW = 256;
    localparam int unsigned TO   = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    imem_loader #(
        .MAX_WORDS      (MAXW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic        exp_err;
    } len_vec_t;

    int       checks = 0;
    int       errors = 0;
    wr_t      exp_q[$];
    wr_t      mon_e;
    len_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every IMEM write is matched against the scoreboard
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", imem_addr, mon_e.addr);
                check("wr_data", imem_wdata, mon_e.data);
                check("wr_byte_ready", 32'(byte_ready), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bit ok;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        waited     = 0;
        ok         = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (byte_ready === 1'b1) ok = 1'b1;
            else waited++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL byte_handshake: got byte_ready low for %0d cycles expected high", waited);
        end
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
        end
    endtask

    task automatic load_words(input int n, input int maxgap);
        logic [31:0] w;
        send_word(32'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: BASE + 32'(4 * i), data: w});
            send_word(w, maxgap);
        end
    endtask

    task automatic finish_load(input string name);
        @(negedge clk);
        check({name, "_we"}, 32'(imem_we), 32'd1);
        @(negedge clk);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
        check({name, "_error"}, 32'(error), 32'd0);
        check({name, "_we_off"}, 32'(imem_we), 32'd0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({name, "_imem_we"}, 32'(imem_we), 32'd0);
        check({name, "_imem_addr"}, imem_addr, BASE);
        check({name, "_imem_wdata"}, imem_wdata, 32'd0);
        check({name, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;

        vecs[0] = '{n: 32'd0,          exp_err: 1'b1};
        vecs[1] = '{n: 32'd257,        exp_err: 1'b1};
        vecs[2] = '{n: 32'd256,        exp_err: 1'b0};
        vecs[3] = '{n: 32'd1,          exp_err: 1'b0};
        vecs[4] = '{n: 32'hFFFF_FFFF,  exp_err: 1'b1};
        vecs[5] = '{n: 32'h0001_0000,  exp_err: 1'b1};

        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        do_reset();
        @(negedge clk);
        check_reset_values("reset");

        // Single word
        pulse_start();
        send_word(32'd1, 0);
        exp_q.push_back('{addr: 32'h0, data: 32'h00A0_0513});
        send_word(32'h00A0_0513, 0);
        finish_load("single");

        // Reload from DONE re-holds the core in the start cycle
        pulse_start();
        @(negedge clk);
        check("reload_core_rst_n", 32'(core_rst_n), 32'd0);
        check("reload_done", 32'(done), 32'd0);
        check("reload_byte_ready", 32'(byte_ready), 32'd1);
        load_words(2, 3);
        finish_load("two_words");

        // Three words with random gaps
        pulse_start();
        load_words(3, 6);
        finish_load("three_words");
        check("three_words_drained", 32'(exp_q.size()), 32'd0);

        // Length acceptance table
        for (int i = 0; i < 6; i++) begin
            do_reset();
            pulse_start();
            send_word(vecs[i].n, 0);
            @(negedge clk);
            check($sformatf("len%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
            check($sformatf("len%0d_byte_ready", i), 32'(byte_ready), 32'(!vecs[i].exp_err));
            check($sformatf("len%0d_core_rst_n", i), 32'(core_rst_n), 32'd0);
            check($sformatf("len%0d_we", i), 32'(imem_we), 32'd0);
        end
        do_reset();

        // Timeout in the middle of word 1
        pulse_start();
        send_word(32'd2, 0);
        w = $urandom;
        exp_q.push_back('{addr: BASE, data: w});
        send_word(w, 2);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        repeat (16) @(negedge clk);
        check("timeout_not_yet", 32'(error), 32'd0);
        @(negedge clk);
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_core_rst_n", 32'(core_rst_n), 32'd0);
        check("timeout_byte_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("timeout_drained", 32'(exp_q.size()), 32'd0);
        pulse_start();
        @(negedge clk);
        check("err_restart_error", 32'(error), 32'd0);
        load_words(1, 2);
        finish_load("after_timeout");

        // Ignored start during DATA, then reset mid-load
        pulse_start();
        send_word(32'd4, 0);
        w = $urandom;
        exp_q.push_back('{addr: BASE, data: w});
        send_word(w, 1);
        tick();
        pulse_start();
        w = $urandom;
        exp_q.push_back('{addr: BASE + 32'd4, data: w});
        send_word(w, 1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midload_rst");
        check("midload_drained", 32'(exp_q.size()), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h33;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_byte_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        @(negedge clk);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
